// File: rtl/trig_engine_arbiter.sv
// Round-robin arbiter/sequencer sharing one Taylor-series float engine between NREQ requesters.
// Optional watchdog abort (quiet-NaN result, rsp_err) enabled by defining TRIG_ARB_TIMEOUT_EN.
module trig_engine_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_x,
  input  logic [NREQ*32-1:0]   req_count,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_res,
  output logic                 rsp_err,
  output logic                 eng_start,
  output logic [31:0]          eng_x,
  output logic [31:0]          eng_count,
  input  logic                 eng_done,
  input  logic [31:0]          eng_res,
  output logic                 busy,
  output logic [2:0]           owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : gBadCfg
    $error("trig_engine_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  stateT                  state, nextState;
  logic [NREQ-1:0][31:0]  xVec, countVec;
  logic [31:0]            xQ, countQ, resQ, selX, selCount;
  logic [2:0]             ownerQ, rrPtr, grantIdx;
  logic [NREQ-1:0]        grantOh, ownerOh;
  logic                   found, waitBlank, accept, timeoutHit, ack;

  assign xVec     = req_x;
  assign countVec = req_count;

  // First set bit at/after rrPtr; second pass covers the wrap-around.
  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    grantOh  = '0;
    selX     = '0;
    selCount = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (pass == 1 || i >= int'(rrPtr))) begin
          found      = 1'b1;
          grantIdx   = 3'(i);
          grantOh[i] = 1'b1;
          selX       = xVec[i];
          selCount   = countVec[i];
        end
      end
    end
  end

  always_comb begin
    ownerOh = '0;
    for (int i = 0; i < NREQ; i++) ownerOh[i] = (ownerQ == 3'(i));
  end

  assign ack    = |(rsp_ready & ownerOh);
  // Done seen in the first WAIT cycle may be left over from the previous run.
  assign accept = eng_done & ~waitBlank;

`ifdef TRIG_ARB_TIMEOUT_EN
  localparam int WaitCntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WaitCntW-1:0] waitCnt;
  logic                errQ;
  assign timeoutHit = (waitCnt == WaitCntW'(TIMEOUT_CYCLES));
`else
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (found) nextState = ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    if (accept || timeoutHit) nextState = RESP;
      RESP:    if (ack) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) ? grantOh : '0;
    rsp_valid = (state == RESP) ? ownerOh : '0;
    eng_start = (state == ISSUE);
    busy      = (state != IDLE);
`ifdef TRIG_ARB_TIMEOUT_EN
    rsp_err   = errQ & (state == RESP);
`else
    rsp_err   = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xQ        <= '0;
      countQ    <= '0;
      resQ      <= '0;
      ownerQ    <= '0;
      rrPtr     <= '0;
      waitBlank <= 1'b0;
    end else begin
      waitBlank <= (state == ISSUE);
      if (state == IDLE && found) begin
        xQ     <= selX;
        countQ <= selCount;
        ownerQ <= grantIdx;
        rrPtr  <= (grantIdx == 3'(NREQ - 1)) ? '0 : grantIdx + 3'd1;
      end
      if (state == WAIT) begin
        if (accept) resQ <= eng_res;
`ifdef TRIG_ARB_TIMEOUT_EN
        else if (timeoutHit) resQ <= 32'h7FC0_0000;
`endif
      end
    end
  end

`ifdef TRIG_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
      errQ    <= 1'b0;
    end else begin
      waitCnt <= (state == WAIT) ? waitCnt + WaitCntW'(1) : '0;
      if (state == WAIT) begin
        if (accept)          errQ <= 1'b0;
        else if (timeoutHit) errQ <= 1'b1;
      end
    end
  end
`endif

  assign eng_x     = xQ;
  assign eng_count = countQ;
  assign rsp_res   = resQ;
  assign owner     = ownerQ;

endmodule

// File: doc/trig_engine_arbiter.md
# trig_engine_arbiter

Round-robin arbiter and sequencer that shares one Taylor-series float evaluation engine (the fsin-class unit: 32-bit IEEE-754 `x`, float term `count`, `res`, `Done`) between `NREQ` requesters. It grants one request at a time and captures the operands. It starts the engine, waits for completion, then returns the result to the owning requester through a valid/ready handshake. It sits between the requester-side float datapaths and the single engine instance.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 64: watchdog limit in cycles. Used only with `TRIG_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_ready` out NREQ: grant/accept strobe, one-hot or zero.
- `req_x` in NREQ*32: operand x; slice i belongs to requester i.
- `req_count` in NREQ*32: float term count; slice i belongs to requester i.
- `rsp_valid` out NREQ: result valid for requester i, one-hot or zero.
- `rsp_ready` in NREQ: requester i accepts the result.
- `rsp_res` out 32: shared result bus.
- `rsp_err` out 1: result came from a watchdog abort.
- `eng_start` out 1: one-cycle start pulse to the engine.
- `eng_x` out 32: operand to the engine; held stable from ISSUE through WAIT.
- `eng_count` out 32: term count to the engine; held stable from ISSUE through WAIT.
- `eng_done` in 1: engine completion level.
- `eng_res` in 32: engine result.
- `busy` out 1: high in every state except IDLE.
- `owner` out 3: index of the current or last granted requester.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` is high, pick the first set bit at or after `rr_ptr`, wrapping modulo NREQ.
  - Drive `req_ready[g]=1` combinationally in that cycle.
  - On the clock edge: capture `req_x[g]` and `req_count[g]` into the operand registers, set `owner=g`, set `rr_ptr=(g+1)%NREQ`, go to ISSUE.
- ISSUE:
  - `eng_start=1` for exactly this cycle.
  - Go to WAIT.
- WAIT:
  - `eng_done` is ignored in the first WAIT cycle, which blanks a stale Done from the previous run.
  - From the second WAIT cycle on, `eng_done=1` latches `eng_res` into `res_q`, clears `err_q`, and moves to RESP.
- RESP:
  - `rsp_valid[owner]=1` and `rsp_res=res_q`, held stable until `rsp_ready[owner]=1`.
  - On that handshake edge, go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- No new grant is issued outside IDLE. `req_ready` is all-zero in ISSUE, WAIT and RESP.
- A requester that drops `req_valid` before its grant is simply skipped; no state is kept.
- Simultaneous requests are resolved by round-robin only. There are no priorities.
- Reset mid-operation:
  - State returns to IDLE and `rr_ptr` to 0.
  - The operand and result registers clear to 0.
  - The in-flight engine result is discarded; a later `eng_done` level in IDLE is ignored.
- `eng_x` and `eng_count` are driven from the operand registers at all times.

## Timing
- Reset values:
  - `req_ready=0`, `rsp_valid=0`, `rsp_res=0`, `rsp_err=0`.
  - `eng_start=0`, `eng_x=0`, `eng_count=0`.
  - `busy=0`, `owner=0`, `rr_ptr=0`.
- Cycle sequence:
  - Cycle 0: grant (IDLE, `req_ready` high).
  - Cycle 1: `eng_start`.
  - Cycles 2..: WAIT.
  - Cycle D+1: RESP begins, where D is the first WAIT cycle after blanking in which `eng_done` is high.
- Minimum grant-to-`rsp_valid` latency is 4 cycles.
- Back-to-back operation: after the RESP handshake edge, the next grant can occur in the following IDLE cycle. Minimum request-to-request spacing is therefore 5 cycles.
- `rsp_valid` and `rsp_res` are registered outputs, not combinational from `eng_done`.

## Configuration
- `TRIG_ARB_TIMEOUT_EN` defined:
  - A WAIT cycle counter starts at 0 on entry to WAIT.
  - If the counter reaches `TIMEOUT_CYCLES` without an accepted `eng_done`, latch `res_q=32'h7FC00000` (quiet NaN), set `err_q=1`, and go to RESP.
  - `rsp_err` mirrors `err_q` while `rsp_valid` is high and is 0 otherwise.
- `TRIG_ARB_TIMEOUT_EN` undefined:
  - No counter exists; WAIT persists indefinitely.
  - `rsp_err` is tied to 0.

## Test plan
- Single request, functional check:
  - Stimulus: requester 0, `x=32'h3F000000`, `count=32'h41000000`; engine model asserts done 10 cycles after start with `32'h3EF57744`.
  - Required: `req_ready[0]` in cycle 0, `eng_start` in cycle 1, `rsp_valid[0]` with `rsp_res=32'h3EF57744` and `rsp_err=0`.
- All four requesters request continuously from reset:
  - Required: grant order 0,1,2,3,0.
  - Required: `eng_x` matches each grantee's `req_x`.
  - Required: no overlapping `eng_start` pulses.
- Stale Done blanking:
  - Stimulus: hold `eng_done=1` across ISSUE and the first WAIT cycle, then drop it; reassert it 5 cycles later.
  - Required: result latched only on the reassertion.
- Response backpressure:
  - Stimulus: hold `rsp_ready[2]=0` for 20 cycles.
  - Required: `rsp_valid[2]` and `rsp_res` stable, no new grant, `busy=1`; handshake then returns to IDLE.
- Reset mid-run:
  - Stimulus: assert `rst_n=0` during WAIT, then release it.
  - Required: all outputs at reset values; a late `eng_done` causes no `rsp_valid`.
  - Required: the next grant goes to the lowest active index.
- Watchdog (with `TRIG_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`):
  - Stimulus: `eng_done` never asserted.
  - Required: `rsp_res=32'h7FC00000` and `rsp_err=1` on `rsp_valid`.
